truth_table_sweeper: RTL and testbench

- Sequential stimulus and capture stage for 3-input combinational logic blocks in the wolfram truth-table set.
- Sits upstream of the logic block: drives in1/in2/in3 through all 8 input rows.
- Sits downstream of it: samples the block's single output after a settle interval and assembles the 8-bit truth-table word.
- Compares the captured word against an expected function code (e.g. 8'h3C).

---
 rtl/truth_table_sweeper.sv | 149 ++++++++++++++
 tb/tb_truth_table_sweeper.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Drives a 3-input combinational block through its eight input rows in
//   ascending order, samples the block's output once per row after a settle
//   interval, assembles the 8-bit truth-table word and compares it against
//   an expected function code.
//
// Parameters
//   SETTLE_CYCLES  cycles each row is held before the sample cycle (1..255)
//   EXPECTED       expected truth-table code, bit i = output for row i,
//                  i = {in1,in2,in3}
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   start        request a sweep (accepted only when idle)
//   abort        abandon the sweep in progress
//   dut_out      output of the block under sweep (synchronous to clk)
//   in1/in2/in3  row MSB / middle / LSB driven to the block
//   busy         high from start acceptance until the last row is captured
//   done         one-cycle pulse when the word is complete
//   truth_table  captured word, held until the next accepted start
//   match        truth_table == EXPECTED, valid with done, held with the word
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  EXPECTED      = 8'h3C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] truth_table,
  output logic       match
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Terminal settle count; SETTLE ends on the edge where the counter
  // holds this value, so SETTLE always lasts exactly SETTLE_CYCLES cycles.
  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state_reg;
  logic [2:0] row_reg;
  logic [7:0] cnt_reg;
  logic [2:0] in_reg;
  logic       busy_reg;
  logic       done_reg;
  logic [7:0] tt_reg;
  logic       match_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      row_reg   <= 3'd0;
      cnt_reg   <= 8'd0;
      in_reg    <= 3'd0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      tt_reg    <= 8'd0;
      match_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // abort asserted alongside start suppresses the start
          if (start && !abort) begin
            row_reg   <= 3'd0;
            cnt_reg   <= 8'd0;
            in_reg    <= 3'd0;
            busy_reg  <= 1'b1;
            tt_reg    <= 8'd0;
            match_reg <= 1'b0;
            state_reg <= SETTLE;
          end
        end

        SETTLE: begin
          if (abort) begin
            // Partial word is kept for inspection; no done pulse.
            in_reg    <= 3'd0;
            busy_reg  <= 1'b0;
            match_reg <= 1'b0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
            if (cnt_reg == CNT_LAST) begin
              state_reg <= SAMPLE;
            end
          end
        end

        SAMPLE: begin
          if (abort) begin
            in_reg    <= 3'd0;
            busy_reg  <= 1'b0;
            match_reg <= 1'b0;
            state_reg <= IDLE;
          end else begin
            // The row is still applied during this cycle, so dut_out has
            // seen SETTLE_CYCLES+1 cycles of stable input when captured.
            tt_reg[row_reg] <= dut_out;
            cnt_reg         <= 8'd0;
            if (row_reg != 3'd7) begin
              row_reg   <= row_reg + 3'd1;
              in_reg    <= row_reg + 3'd1;
              state_reg <= SETTLE;
            end else begin
              // Last row captured: release the block inputs and drop busy
              // while the comparison is formed in FINISH.
              in_reg    <= 3'd0;
              busy_reg  <= 1'b0;
              state_reg <= FINISH;
            end
          end
        end

        FINISH: begin
          // start and abort are both ignored here.
          done_reg  <= 1'b1;
          match_reg <= (tt_reg == EXPECTED);
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign in1         = in_reg[2];
  assign in2         = in_reg[1];
  assign in3         = in_reg[0];
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign truth_table = tt_reg;
  assign match       = match_reg;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper
//   Two sweeper instances share clock and reset: u_dut4 (SETTLE_CYCLES=4)
//   covers sweep results, done/busy timing, restart-ignore, abort and async
//   reset; u_dut1 (SETTLE_CYCLES=1) covers row sequencing and glitch
//   rejection. Expected words and done cycles are queued when a start is
//   driven and popped when the DUT pulses done.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance with SETTLE_CYCLES = 4
  logic       start4 = 1'b0, abort4 = 1'b0, dut_out4;
  logic       in1_4, in2_4, in3_4, busy4, done4, match4;
  logic [7:0] tt4;
  logic [1:0] mode4 = 2'd0;   // 0: in1^in2, 1: constant 1, 2: constant 0

  // Instance with SETTLE_CYCLES = 1
  logic       start1 = 1'b0, abort1 = 1'b0, dut_out1;
  logic       in1_1, in2_1, in3_1, busy1, done1, match1;
  logic [7:0] tt1;
  logic       glitch1 = 1'b0;

  assign dut_out4 = (mode4 == 2'd0) ? (in1_4 ^ in2_4) : (mode4 == 2'd1);
  assign dut_out1 = (in1_1 ^ in2_1) ^ glitch1;

  truth_table_sweeper #(.SETTLE_CYCLES(4), .EXPECTED(8'h3C)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort4), .dut_out(dut_out4),
    .in1(in1_4), .in2(in2_4), .in3(in3_4), .busy(busy4), .done(done4),
    .truth_table(tt4), .match(match4)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(8'h3C)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .dut_out(dut_out1),
    .in1(in1_1), .in2(in2_1), .in3(in3_1), .busy(busy1), .done(done1),
    .truth_table(tt1), .match(match1)
  );

  typedef struct {
    logic [7:0] tt;
    logic       m;
    int         done_cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Pop the scoreboard entry for a done pulse seen on u_dut4.
  task automatic score4();
    exp_t e;
    if (q4.size() == 0) begin
      check("done4_unexpected", 32'd1, 32'd0);
    end else begin
      e = q4.pop_front();
      check("tt4", tt4, e.tt);
      check("match4", match4, e.m);
      check("done4_cycle", cyc, e.done_cyc);
      $display("sweep4: tt=%02h match=%0b at cycle %0d", tt4, match4, cyc);
    end
  endtask

  // Full sweep on u_dut4. restart_at>0 re-pulses start that many cycles
  // after the accepting edge; it must have no effect.
  task automatic sweep4(input logic [7:0] exp_tt, input logic exp_m, input int restart_at);
    int   t0;
    int   busy_n;
    logic got;
    exp_t e;
    @(negedge clk);
    start4 = 1'b1;
    t0 = cyc + 1;
    e.tt = exp_tt; e.m = exp_m; e.done_cyc = t0 + 41;
    q4.push_back(e);
    busy_n = 0;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      start4 = (restart_at > 0) && (cyc == t0 + restart_at);
      if (busy4) busy_n++;
      if (done4) begin
        got = 1'b1;
        score4();
      end
    end
    start4 = 1'b0;
    check("done4_seen", got, 1'b1);
    check("busy4_len", busy_n, 40);
    @(negedge clk);
    check("done4_width", done4, 1'b0);
  endtask

  initial begin
    int   t0;
    logic got;
    int   ndone;
    exp_t e;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out4", {in1_4, in2_4, in3_4, busy4, done4, tt4, match4}, 32'd0);
    check("rst_out1", {in1_1, in2_1, in3_1, busy1, done1, tt1, match1}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // XOR block, plain sweep then a sweep with an ignored restart at cycle 10
    mode4 = 2'd0;
    sweep4(8'h3C, 1'b1, 0);
    sweep4(8'h3C, 1'b1, 10);

    // Constant outputs
    mode4 = 2'd1;
    sweep4(8'hFF, 1'b0, 0);
    mode4 = 2'd2;
    sweep4(8'h00, 1'b0, 0);
    mode4 = 2'd0;

    // Row sequencing and glitch rejection on u_dut1
    @(negedge clk);
    start1 = 1'b1;
    t0 = cyc + 1;
    e.tt = 8'h3C; e.m = 1'b1; e.done_cyc = t0 + 17;
    q1.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      start1  = 1'b0;
      // Glitch covers only the first (non-sampled) cycle of row 2.
      glitch1 = (k == 4);
      if (k <= 16)
        check($sformatf("row1_k%0d", k), {in1_1, in2_1, in3_1}, (k < 16) ? (k >> 1) : 0);
      if (done1) begin
        got = 1'b1;
        if (q1.size() == 0) begin
          check("done1_unexpected", 32'd1, 32'd0);
        end else begin
          e = q1.pop_front();
          check("tt1", tt1, e.tt);
          check("match1", match1, e.m);
          check("done1_cycle", cyc, e.done_cyc);
          $display("sweep1: tt=%02h match=%0b at cycle %0d", tt1, match1, cyc);
        end
      end
    end
    glitch1 = 1'b0;
    check("done1_seen", got, 1'b1);

    // Abort during row 3
    @(negedge clk);
    start4 = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      start4 = 1'b0;
      if ({in1_4, in2_4, in3_4} == 3'b011) got = 1'b1;
    end
    check("abort_row3_reached", got, 1'b1);
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    check("abort_busy", busy4, 1'b0);
    check("abort_in", {in1_4, in2_4, in3_4}, 3'b000);
    check("abort_tt", tt4, 8'h04);
    check("abort_match", match4, 1'b0);
    ndone = 0;
    repeat (50) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    check("abort_no_done", ndone, 0);
    $display("abort: tt=%02h busy=%0b", tt4, busy4);

    // start and abort together in IDLE: abort wins
    start4 = 1'b1;
    abort4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    abort4 = 1'b0;
    check("start_abort_busy", busy4, 1'b0);

    // Asynchronous reset mid-SETTLE
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_out4", {in1_4, in2_4, in3_4, busy4, done4, tt4, match4}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (45) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    check("arst_no_done", ndone, 0);
    sweep4(8'h3C, 1'b1, 0);

    check("sb4_empty", q4.size(), 0);
    check("sb1_empty", q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
